// File: rtl/jk_lockstep_checker.sv
// jk_lockstep_checker
//   Lockstep monitor for three JK flip-flop implementations (SR-, D- and
//   T-based). It runs a golden JK reference model on the same j/k inputs.
//   While checking, it compares each flop output against that model.
//
//   Ports
//     clk             rising-edge clock shared with the monitored flops
//     reset           asynchronous, active-high reset
//     en              checking enable
//     clr             synchronous clear of the error state
//     j, k            JK inputs, the same nets that drive the flops
//     q_sr, q_d, q_t  outputs of the three flop implementations
//     q_ref           golden model state
//     err_sr/d/t      registered per-flop mismatch pulses
//     mism_cnt        saturating count of mismatching cycles
//     first_fail      {sr,d,t} bitmap captured on the first mismatching cycle
//     fault           sticky fault flag
//
//   States
//     IDLE   the model resynchronises to the majority of the three flops
//     CHECK  the model free-runs and the flops are compared against it
//     FAULT  like CHECK, but sticky; only clr or reset leaves it

module jk_lockstep_checker #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned FAULT_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             j,
  input  logic             k,
  input  logic             q_sr,
  input  logic             q_d,
  input  logic             q_t,
  output logic             q_ref,
  output logic             err_sr,
  output logic             err_d,
  output logic             err_t,
  output logic [CNT_W-1:0] mism_cnt,
  output logic [2:0]       first_fail,
  output logic             fault
);

  // FSM encoding
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCheck = 2'd1;
  localparam logic [1:0] StFault = 2'd2;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  // Counter value from which the next mismatch reaches the fault limit.
  localparam logic [CNT_W-1:0] LimitM1 = CNT_W'(FAULT_LIMIT - 1);

  // Reference JK next-state function.
  function automatic logic jk_next(input logic q, input logic jj, input logic kk);
    logic r;
    case ({jj, kk})
      2'b00:   r = q;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic             q_ref_q, q_ref_d;
  logic [2:0]       err_q, err_d_vec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ff_q, ff_d;
  logic             fault_q, fault_d;

  logic             checking;
  logic             maj;
  logic [2:0]       cmp;
  logic             mism;
  logic             hit_limit;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    checking  = (state_q == StCheck) || (state_q == StFault);
    maj       = (q_sr & q_d) | (q_sr & q_t) | (q_d & q_t);

    // Resync to the flops in IDLE, free-run otherwise. q_ref is unaffected by clr.
    q_ref_d   = jk_next(checking ? q_ref_q : maj, j, k);

    cmp       = checking ? ({q_sr, q_d, q_t} ^ {3{q_ref_q}}) : 3'b000;
    mism      = |cmp;
    cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
    hit_limit = mism && (cnt_q == LimitM1);

    err_d_vec = cmp;
    cnt_d     = mism ? cnt_inc : cnt_q;
    // first_fail is zero until the first mismatch, so zero marks "not yet captured".
    ff_d      = (mism && (ff_q == 3'b000)) ? cmp : ff_q;
    fault_d   = fault_q;
    state_d   = state_q;

    case (state_q)
      StIdle: begin
        if (en) state_d = StCheck;
      end
      StCheck: begin
        // Reaching the limit wins over dropping en.
        if (hit_limit) begin
          state_d = StFault;
          fault_d = 1'b1;
        end else if (!en) begin
          state_d = StIdle;
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // clr overrides any mismatch seen in the same cycle.
    if (clr) begin
      err_d_vec = 3'b000;
      cnt_d     = '0;
      ff_d      = 3'b000;
      fault_d   = 1'b0;
      state_d   = en ? StCheck : StIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      q_ref_q <= 1'b0;
      err_q   <= 3'b000;
      cnt_q   <= '0;
      ff_q    <= 3'b000;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_ref_q <= q_ref_d;
      err_q   <= err_d_vec;
      cnt_q   <= cnt_d;
      ff_q    <= ff_d;
      fault_q <= fault_d;
    end
  end

  assign q_ref      = q_ref_q;
  assign err_sr     = err_q[2];
  assign err_d      = err_q[1];
  assign err_t      = err_q[0];
  assign mism_cnt   = cnt_q;
  assign first_fail = ff_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_jk_lockstep_checker.sv
// Testbench for jk_lockstep_checker. Instance a uses the default parameters,
// instance b uses CNT_W=3 to exercise counter saturation.

module tb_jk_lockstep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  logic       a_en = 0, a_clr = 0, a_j = 0, a_k = 0, a_qsr = 0, a_qd = 0, a_qt = 0;
  logic       a_qref, a_esr, a_ed, a_et, a_fault;
  logic [7:0] a_cnt;
  logic [2:0] a_ff;

  logic       b_en = 0, b_clr = 0, b_j = 0, b_k = 0, b_qsr = 0, b_qd = 0, b_qt = 0;
  logic       b_qref, b_esr, b_ed, b_et, b_fault;
  logic [2:0] b_cnt;
  logic [2:0] b_ff;

  jk_lockstep_checker #(.CNT_W(8), .FAULT_LIMIT(4)) u_a (
    .clk(clk), .reset(reset), .en(a_en), .clr(a_clr), .j(a_j), .k(a_k),
    .q_sr(a_qsr), .q_d(a_qd), .q_t(a_qt), .q_ref(a_qref),
    .err_sr(a_esr), .err_d(a_ed), .err_t(a_et),
    .mism_cnt(a_cnt), .first_fail(a_ff), .fault(a_fault)
  );

  jk_lockstep_checker #(.CNT_W(3), .FAULT_LIMIT(4)) u_b (
    .clk(clk), .reset(reset), .en(b_en), .clr(b_clr), .j(b_j), .k(b_k),
    .q_sr(b_qsr), .q_d(b_qd), .q_t(b_qt), .q_ref(b_qref),
    .err_sr(b_esr), .err_d(b_ed), .err_t(b_et),
    .mism_cnt(b_cnt), .first_fail(b_ff), .fault(b_fault)
  );

  typedef struct {
    string      name;
    bit         sel;
    logic       qref;
    logic [2:0] err;
    logic [7:0] cnt;
    logic [2:0] ff;
    logic       flt;
  } exp_t;

  exp_t sb[$];
  event imm_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input string f, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", nm, f, act, exp);
    end
  endtask

  // Monitor: after each rising edge (or an immediate-check event) drain the scoreboard.
  initial begin
    exp_t r;
    forever begin
      @(posedge clk or imm_ev);
      #2;
      while (sb.size() > 0) begin
        r = sb.pop_front();
        if (!r.sel) begin
          chk(r.name, "q_ref",      {7'b0, a_qref},             {7'b0, r.qref});
          chk(r.name, "err",        {5'b0, a_esr, a_ed, a_et},  {5'b0, r.err});
          chk(r.name, "mism_cnt",   a_cnt,                      r.cnt);
          chk(r.name, "first_fail", {5'b0, a_ff},               {5'b0, r.ff});
          chk(r.name, "fault",      {7'b0, a_fault},            {7'b0, r.flt});
        end else begin
          chk(r.name, "q_ref",      {7'b0, b_qref},             {7'b0, r.qref});
          chk(r.name, "err",        {5'b0, b_esr, b_ed, b_et},  {5'b0, r.err});
          chk(r.name, "mism_cnt",   {5'b0, b_cnt},              r.cnt);
          chk(r.name, "first_fail", {5'b0, b_ff},               {5'b0, r.ff});
          chk(r.name, "fault",      {7'b0, b_fault},            {7'b0, r.flt});
        end
      end
    end
  end

  // Drive one cycle of inputs (q = {sr,d,t}) and queue the state expected after the edge.
  task automatic step(input string nm, input bit sel, input logic en, input logic clr,
                      input logic j, input logic k, input logic [2:0] q,
                      input logic eq, input logic [2:0] ee, input logic [7:0] ec,
                      input logic [2:0] ef, input logic eflt);
    exp_t r;
    @(negedge clk);
    if (!sel) begin
      a_en = en; a_clr = clr; a_j = j; a_k = k; a_qsr = q[2]; a_qd = q[1]; a_qt = q[0];
    end else begin
      b_en = en; b_clr = clr; b_j = j; b_k = k; b_qsr = q[2]; b_qd = q[1]; b_qt = q[0];
    end
    r.name = nm; r.sel = sel; r.qref = eq; r.err = ee; r.cnt = ec; r.ff = ef; r.flt = eflt;
    sb.push_back(r);
  endtask

  // Assert reset between edges and check both instances before the next edge.
  task automatic reset_now(input string nm);
    exp_t r;
    @(negedge clk);
    reset = 1'b1;
    a_en = 0; a_clr = 0; a_j = 0; a_k = 0; a_qsr = 0; a_qd = 0; a_qt = 0;
    b_en = 0; b_clr = 0; b_j = 0; b_k = 0; b_qsr = 0; b_qd = 0; b_qt = 0;
    #1;
    r.name = nm; r.sel = 1'b0; r.qref = 0; r.err = 0; r.cnt = 0; r.ff = 0; r.flt = 0;
    sb.push_back(r);
    r.sel = 1'b1;
    sb.push_back(r);
    -> imm_ev;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_now("por");

    // Healthy flops, jk = 00,01,10,11,11 -> q_ref 0,0,1,0,1
    //           name       s en c j k q       qref err     cnt ff      flt
    step("h_jk00",  0, 1, 0, 0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 0);
    step("h_jk01",  0, 1, 0, 0, 1, 3'b000, 0, 3'b000, 0, 3'b000, 0);
    step("h_jk10",  0, 1, 0, 1, 0, 3'b000, 1, 3'b000, 0, 3'b000, 0);
    step("h_jk11a", 0, 1, 0, 1, 1, 3'b111, 0, 3'b000, 0, 3'b000, 0);
    step("h_jk11b", 0, 1, 0, 1, 1, 3'b000, 1, 3'b000, 0, 3'b000, 0);

    // q_d stuck at 0 while q_ref=1; fault on the 4th mismatch
    step("sd_1",    0, 1, 0, 0, 0, 3'b101, 1, 3'b010, 1, 3'b010, 0);
    step("sd_2",    0, 1, 0, 0, 0, 3'b101, 1, 3'b010, 2, 3'b010, 0);
    step("sd_3",    0, 1, 0, 0, 0, 3'b101, 1, 3'b010, 3, 3'b010, 0);
    step("sd_4",    0, 1, 0, 0, 0, 3'b101, 1, 3'b010, 4, 3'b010, 1);

    // FAULT ignores en and keeps comparing against the free-running model
    step("flt_en0", 0, 0, 0, 0, 0, 3'b111, 1, 3'b000, 4, 3'b010, 1);
    step("flt_cmp", 0, 0, 0, 0, 0, 3'b000, 1, 3'b111, 5, 3'b010, 1);

    // clr together with a mismatch wins; en=1 goes to CHECK
    step("clr_mis", 0, 1, 1, 0, 0, 3'b011, 1, 3'b000, 0, 3'b000, 0);
    step("post_clr",0, 1, 0, 0, 0, 3'b110, 1, 3'b001, 1, 3'b001, 0);

    // Drop en in CHECK with q={1,1,0}, jk=00 -> IDLE, model resyncs to majority
    step("ck_en0",  0, 0, 0, 0, 0, 3'b110, 1, 3'b001, 2, 3'b001, 0);
    step("idle_rs1",0, 0, 0, 0, 0, 3'b110, 1, 3'b000, 2, 3'b001, 0);
    step("idle_rs0",0, 0, 0, 0, 0, 3'b001, 0, 3'b000, 2, 3'b001, 0);
    step("idle_j",  0, 0, 0, 1, 0, 3'b000, 1, 3'b000, 2, 3'b001, 0);

    // Back to CHECK, reach mism_cnt=3, then reset mid-cycle
    step("re_en",   0, 1, 0, 0, 0, 3'b111, 1, 3'b000, 2, 3'b001, 0);
    step("re_mis",  0, 1, 0, 0, 0, 3'b101, 1, 3'b010, 3, 3'b001, 0);
    reset_now("rst_mid");
    // In IDLE after reset: no compare despite q != q_ref
    step("pr_idle", 0, 1, 0, 0, 0, 3'b111, 1, 3'b000, 0, 3'b000, 0);
    step("pr_chk",  0, 0, 0, 0, 0, 3'b111, 1, 3'b000, 0, 3'b000, 0);

    // CNT_W=3: ten mismatching cycles saturate at 7, fault from the 4th
    step("b_en",    1, 1, 0, 0, 0, 3'b000, 0, 3'b000, 0, 3'b000, 0);
    for (int i = 1; i <= 10; i++) begin
      step($sformatf("b_sat%0d", i), 1, 1, 0, 0, 0, 3'b111, 0, 3'b111,
           (i > 7) ? 8'd7 : 8'(i), 3'b111, (i >= 4) ? 1'b1 : 1'b0);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
